// File: rtl/ep_arb_pkg.sv
// Shared types and helpers for the endpoint TRN-tx arbiter.
package ep_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    DRIVE = 2'd2,
    GAP   = 2'd3
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Index width for ptr/owner; never narrower than one bit so NCH=1 still has a field.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/ep_arb_rr_sel.sv
// Round-robin pick: first set request at or after ptr, wrapping to index 0.
module ep_arb_rr_sel
  import ep_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic           sel_vld,
  output logic [IW-1:0]  sel_idx
);

  logic          hi_vld;
  logic          lo_vld;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // Scan downward so the lowest qualifying index in each half is the one left standing.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (req[j]) begin
        if (j >= int'(ptr)) begin
          hi_vld = 1'b1;
          hi_idx = IW'(j);
        end else begin
          lo_vld = 1'b1;
          lo_idx = IW'(j);
        end
      end
    end
    sel_vld = hi_vld | lo_vld;
    sel_idx = hi_vld ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/ep_arb.sv
// Endpoint arbiter: hands the shared TRN tx turn to one channel at a time,
// round-robin, and flags channels that drive without holding the turn.
module ep_arb
  import ep_arb_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int OFFER_TO = 4,
  parameter int CW       = 3
) (
  input  logic           pcie_clk,
  input  logic           pcie_rst_n,
  input  logic [NCH-1:0] chn_reqep,
  input  logic [NCH-1:0] chn_drvn,
  output logic [NCH-1:0] chn_trn,
  input  logic           err_clr,
  output logic           arb_err,
  output state_e         state_dbg
);

  localparam int IW = idx_w(NCH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [NCH-1:0]   trn_q, trn_d;
  logic             err_q, err_d;
  logic             sel_vld;
  logic [IW-1:0]    sel_idx;
  logic             drv_own;

  ep_arb_rr_sel #(.NCH(NCH), .IW(IW)) u_rr_sel (
    .req     (chn_reqep),
    .ptr     (ptr_q),
    .sel_vld (sel_vld),
    .sel_idx (sel_idx)
  );

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      trn_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      trn_q   <= trn_d;
      err_q   <= err_d;
    end
  end

  // trn_q only ever holds the owner's bit, so this is "owner is driving".
  assign drv_own = |(chn_drvn & trn_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    trn_d   = trn_q;
    err_d   = (|(chn_drvn & ~trn_q)) | (err_q & ~err_clr);
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = OFFER;
          owner_d = sel_idx;
          trn_d   = NCH'(1) << sel_idx;
          cnt_d   = '0;
        end
      end
      OFFER: begin
        if (drv_own) begin
          state_d = DRIVE;
        end else if (cnt_q == CW'(OFFER_TO - 1)) begin
          state_d = GAP;
          trn_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRIVE: begin
        if (!drv_own) begin
          state_d = GAP;
          trn_d   = '0;
        end
      end
      GAP: begin
        state_d = IDLE;
        ptr_d   = (owner_q == IW'(NCH - 1)) ? '0 : owner_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chn_trn   = trn_q;
    arb_err   = err_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_ep_arb.sv
// Directed bench for ep_arb: a cycle table on a 2-channel arbiter plus
// hand sequences for async reset and wrap-around on a 3-channel instance.
module tb_ep_arb;
  import ep_arb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] req2, drv2, trn2;
  logic       clr2, err2;
  state_e     st2;
  logic [2:0] req3, drv3, trn3;
  logic       clr3, err3;
  state_e     st3;

  int n_vec;
  int n_bad;

  ep_arb #(.NCH(2), .OFFER_TO(4), .CW(3)) u_dut2 (
    .pcie_clk   (clk),
    .pcie_rst_n (rst_n),
    .chn_reqep  (req2),
    .chn_drvn   (drv2),
    .chn_trn    (trn2),
    .err_clr    (clr2),
    .arb_err    (err2),
    .state_dbg  (st2)
  );

  ep_arb #(.NCH(3), .OFFER_TO(4), .CW(3)) u_dut3 (
    .pcie_clk   (clk),
    .pcie_rst_n (rst_n),
    .chn_reqep  (req3),
    .chn_drvn   (drv3),
    .chn_trn    (trn3),
    .err_clr    (clr3),
    .arb_err    (err3),
    .state_dbg  (st3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record: inputs held during cycle t, outputs required in cycle t+1.
  typedef struct packed {
    logic [1:0] req;
    logic [1:0] drv;
    logic       clr;
    logic [1:0] trn;
    logic       err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] req, input logic [1:0] drv, input logic clr,
                     input logic [1:0] trn, input logic err);
    vec_t v;
    v.req = req; v.drv = drv; v.clr = clr; v.trn = trn; v.err = err;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req2 = '0; drv2 = '0; clr2 = 1'b0;
    req3 = '0; drv3 = '0; clr3 = 1'b0;

    // Single request, grant to ch0, release, then ch1 next via rr.
    add(2'b01, 2'b00, 0, 2'b01, 0);
    add(2'b00, 2'b00, 0, 2'b01, 0);
    add(2'b00, 2'b01, 0, 2'b01, 0);
    add(2'b00, 2'b01, 0, 2'b01, 0);
    add(2'b00, 2'b01, 0, 2'b01, 0);
    add(2'b00, 2'b01, 0, 2'b01, 0);
    add(2'b00, 2'b00, 0, 2'b00, 0);
    add(2'b10, 2'b00, 0, 2'b00, 0);
    add(2'b11, 2'b00, 0, 2'b10, 0);
    // ch1 never drives: four offered cycles then timeout, next grant ch0.
    add(2'b11, 2'b00, 0, 2'b10, 0);
    add(2'b11, 2'b00, 0, 2'b10, 0);
    add(2'b11, 2'b00, 0, 2'b10, 0);
    add(2'b11, 2'b00, 0, 2'b00, 0);
    add(2'b11, 2'b00, 0, 2'b00, 0);
    add(2'b11, 2'b00, 0, 2'b01, 0);
    // Contention: each owner drives 3 cycles, alternating grants.
    add(2'b11, 2'b01, 0, 2'b01, 0);
    add(2'b11, 2'b01, 0, 2'b01, 0);
    add(2'b11, 2'b01, 0, 2'b01, 0);
    add(2'b11, 2'b00, 0, 2'b00, 0);
    add(2'b11, 2'b00, 0, 2'b00, 0);
    add(2'b11, 2'b00, 0, 2'b10, 0);
    add(2'b11, 2'b10, 0, 2'b10, 0);
    add(2'b11, 2'b10, 0, 2'b10, 0);
    add(2'b11, 2'b10, 0, 2'b10, 0);
    add(2'b11, 2'b00, 0, 2'b00, 0);
    add(2'b11, 2'b00, 0, 2'b00, 0);
    add(2'b11, 2'b00, 0, 2'b01, 0);
    // Protocol error while ch0 is offered; sticky, set beats clear.
    add(2'b00, 2'b10, 0, 2'b01, 1);
    add(2'b00, 2'b00, 0, 2'b01, 1);
    add(2'b00, 2'b10, 1, 2'b01, 1);
    add(2'b00, 2'b00, 1, 2'b00, 0);
    add(2'b00, 2'b00, 0, 2'b00, 0);
    // ch1 granted and driving, then an error raised, ahead of the reset test.
    add(2'b11, 2'b00, 0, 2'b10, 0);
    add(2'b11, 2'b10, 0, 2'b10, 0);
    add(2'b11, 2'b11, 0, 2'b10, 1);

    #12;
    check("rst_trn", trn2, 2'b00);
    check("rst_err", err2, 0);
    check("rst_state", st2, IDLE);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      req2 = vq[i].req;
      drv2 = vq[i].drv;
      clr2 = vq[i].clr;
      tick();
      check($sformatf("v%0d_trn", i), trn2, vq[i].trn);
      check($sformatf("v%0d_err", i), err2, vq[i].err);
      check($sformatf("v%0d_onehot", i), ($countones(trn2) <= 1) ? 1 : 0, 1);
    end

    // Async reset mid-drive: outputs drop with no clock edge.
    check("pre_rst_state", st2, DRIVE);
    rst_n = 1'b0;
    #1;
    check("async_rst_trn", trn2, 2'b00);
    check("async_rst_err", err2, 0);
    req2 = 2'b11; drv2 = 2'b00; clr2 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_grant", trn2, 2'b01);

    // Wrap-around on NCH=3: serve ch1 so ptr lands on 2, then 011 must pick ch0.
    req3 = 3'b010;
    tick();
    check("w_grant1", trn3, 3'b010);
    drv3 = 3'b010;
    tick();
    check("w_drive", trn3, 3'b010);
    drv3 = 3'b000;
    req3 = 3'b000;
    tick();
    check("w_gap", trn3, 3'b000);
    req3 = 3'b011;
    tick();
    check("w_idle", trn3, 3'b000);
    tick();
    check("w_wrap", trn3, 3'b001);
    check("w_err", err3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ep_arb.md
Name: ep_arb

Overview:
- Endpoint-level arbiter: the granting end of the per-channel EP-arb handshake (chn_trn / chn_drvn / chn_reqep).
- Sits between the PCIe endpoint's shared TRN tx interface and NCH channel instances.
- Gives exactly one channel at a time the turn to drive TRN tx, round-robin among requesters.
- Detects handshake violations and reports them on a sticky error flag.

Parameters:
- NCH, 2, number of channels; NCH >= 1.
- OFFER_TO, 4, cycles a granted channel has to assert chn_drvn before the turn is withdrawn; >= 2.
- CW, 3, offer counter width; must hold OFFER_TO-1.

Ports:
- pcie_clk  in  1  clock; all logic is in this single domain.
- pcie_rst_n  in  1  asynchronous active-low reset.
- chn_reqep  in  NCH  per-channel request for a turn.
- chn_drvn  in  NCH  per-channel "currently driving TRN tx".
- chn_trn  out  NCH  one-hot (or zero) registered turn grant.
- err_clr  in  1  clears arb_err.
- arb_err  out  1  sticky handshake-violation flag.

Interface: one clock (pcie_clk); reset is asynchronous and active-low (pcie_rst_n).

Behaviour:
- Reset (async assert): chn_trn=0, arb_err=0, state=IDLE, rr pointer ptr=0, offer counter=0. Outputs drop immediately, including mid-DRIVE.
- chn_trn is always registered, never more than one bit set.
- IDLE:
  - If any chn_reqep bit is set, select the first set index i at or after ptr, wrapping modulo NCH.
  - Next edge: chn_trn[i]=1, cnt=0, go to OFFER.
  - If no request, stay in IDLE.
- OFFER: hold chn_trn[i].
  - If chn_drvn[i]=1, go to DRIVE.
  - Else if cnt==OFFER_TO-1, clear chn_trn and go to GAP (timeout).
  - Else cnt++.
  - chn_reqep[i] dropping during OFFER is ignored.
- DRIVE: hold chn_trn[i] while chn_drvn[i]=1.
  - On the first cycle chn_drvn[i]=0, clear chn_trn at the next edge and go to GAP.
  - No maximum hold time.
- GAP: one cycle with chn_trn=0; ptr=(i+1) mod NCH; go to IDLE.
- Latency:
  - chn_reqep seen in cycle t gives chn_trn high in t+1.
  - chn_drvn falling in cycle t gives chn_trn low in t+1, and the earliest next grant in t+3.
  - So there are at least 2 all-zero cycles between owners.
- Timeout: the channel loses its turn (ptr advances) and must re-request; if it is the only requester it is re-offered after the gap.
- NCH=1: ptr stays 0; the same sequencing applies.
- Error:
  - arb_err sets at the next edge if any chn_drvn[j]=1 while chn_trn[j]=0.
  - err_clr clears it; set wins over a simultaneous clear.
  - Errors do not change the FSM.
- Channels with chn_reqep=0 are never offered.

Decomposition:
- Package ep_arb_pkg:
  - state enum {IDLE, OFFER, DRIVE, GAP}.
  - function clog2.
  - localparam IW=clog2(NCH) (min 1) for ptr/owner index.
- One natural sub-module: rr_sel, combinational. Inputs req[NCH] and ptr[IW]; outputs sel_vld and sel_idx[IW]. Returns the first set bit at or after ptr, with wrap.

Test Plan:
1. Single request (NCH=2):
   - Stimulus: reqep=01 at cycle 0; drvn[0]=1 in cycles 2-5, 0 from cycle 6.
   - Required: chn_trn=01 in cycles 1-6, 00 from cycle 7; next grant goes to ch1 if it requests.
2. Contention:
   - Stimulus: reqep=11 held; each owner drives 3 cycles after its grant.
   - Required: grants 01,10,01,10; never two bits set; >=2 zero cycles between grants.
3. Offer timeout:
   - Stimulus: reqep=10, drvn never asserted.
   - Required: chn_trn=10 for exactly 4 cycles, then 00; ptr=0; with reqep=11 the next grant is 01.
4. Protocol error:
   - Stimulus: drvn=10 while chn_trn=01.
   - Required: arb_err=1 next cycle and held; err_clr with simultaneous violation leaves it 1; err_clr alone gives 0 next cycle.
5. Reset mid-drive:
   - Stimulus: pcie_rst_n low while chn_trn=10 in DRIVE.
   - Required: chn_trn=00 and arb_err=0 without a clock edge; after release with reqep=11, first grant is 01.
6. Wrap-around (NCH=3):
   - Stimulus: ptr=2, reqep=011.
   - Required: grant 001 (index 0), not 010.
